fft_frame_seq: RTL
==================

Name: fft_frame_seq

Overview:
- Parametrised successor to the single-channel ADC→FFT glue.
- Accepts deserialised ADC samples with a valid strobe and buffers them into ping-pong frames of N = 2^LOG2N samples.
- Streams each complete frame to the radix-2 DIT FFT in bit-reversed order under a valid/ready handshake.
- Scans the FFT output stream for the peak-magnitude bin inside two configurable bin windows (730 nm / 850 nm bands) and reports both peaks once per frame.

Parameters:
- DATLEN, 12, ADC sample width.
- LOG2N, 4, log2 of frame length N.
- FFT_W, 12, width of each of re/im in FFT output words.
- OFFSET_BIN, 1: 1 = invert sample MSB (offset-binary → two's complement) before FFT; 0 = pass unchanged.
- A_LO, 1, first bin of window A (inclusive).
- A_HI, 3, last bin of window A (inclusive).
- B_LO, 4, first bin of window B (inclusive).
- B_HI, 7, last bin of window B (inclusive).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- smp_data  in  DATLEN  ADC sample.
- smp_valid  in  1  sample strobe, one sample per high cycle.
- fft_in_data  out  2*DATLEN  {real, imag}; imag always 0.
- fft_in_valid  out  1  fft_in_data valid.
- fft_in_ready  in  1  FFT accepts the word.
- fft_in_last  out  1  high on the final word of a frame.
- fft_out_data  in  2*FFT_W  {re, im}, two's complement.
- fft_out_valid  in  1  FFT output word valid.
- fft_out_last  in  1  final output bin of a frame.
- clr_overrun  in  1  clears overrun.
- max_a  out  FFT_W+1  peak |re|+|im| in window A.
- idx_a  out  LOG2N  bin index of max_a.
- max_b  out  FFT_W+1  peak magnitude in window B.
- idx_b  out  LOG2N  bin index of max_b.
- max_valid  out  1  one-cycle pulse when max_*/idx_* update.
- overrun  out  1  sticky: a sample was dropped.

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; wr_bank = rd_bank = 0; wr_cnt = rd_cnt = bin_cnt = 0; both full flags 0; running peaks 0.
  - RAM contents undefined.
- Write side:
  - On smp_valid, if full[wr_bank] = 0, store into bank[wr_bank][wr_cnt] and increment wr_cnt.
  - When wr_cnt = N-1 is written: set full[wr_bank], toggle wr_bank, wr_cnt ← 0 (wrap).
  - If full[wr_bank] = 1: drop the sample, set overrun, leave wr_cnt unchanged.
  - clr_overrun clears overrun; a drop in the same cycle wins (overrun stays 1).
- Read FSM:
  - IDLE: if full[rd_bank], go to STREAM with rd_cnt = 0.
  - STREAM:
    - fft_in_valid = 1.
    - real = bank[rd_bank][bitrev(rd_cnt)], with MSB inverted if OFFSET_BIN.
    - fft_in_last = (rd_cnt = N-1).
  - On valid & ready: rd_cnt++. If rd_cnt = N-1: clear full[rd_bank], toggle rd_bank, go to IDLE.
  - Stalled word (valid & !ready): data and last held stable.
- Outputs are registered. fft_in_valid first rises exactly 2 clocks after the edge that captured sample N-1.
- A full-flag set (write side) and clear (read side) on different banks in the same cycle both take effect.
- Peak side, on each fft_out_valid:
  - mag = |re| + |im|, FFT_W+1 bits unsigned. |−2^(FFT_W-1)| = 2^(FFT_W-1) with no saturation.
  - If A_LO ≤ bin_cnt ≤ A_HI and mag > run_a (strict): run_a ← mag, run_ia ← bin_cnt. Window B is handled the same way.
  - Ties: lowest bin wins. An all-zero window reports max 0 at index = window LO.
  - bin_cnt increments and wraps at N-1.
- Frame end is fft_out_valid & (fft_out_last | bin_cnt = N-1). On the next clock:
  - max_a, idx_a, max_b, idx_b ← running values (including the current word);
  - max_valid pulses for 1 cycle;
  - running peaks clear and bin_cnt ← 0.
  - An early fft_out_last resynchronises bin_cnt.
- Reset mid-frame: partial frames are discarded; the next frame starts at bank 0, sample 0.

Test Plan:
- 16 samples 0x800..0x80F, fft_in_ready = 1 → 16 words, real = 0x000,0x008,0x004,0x00C,… (bitrev, MSB inverted); last on the 16th; valid rises 2 clocks after sample 15.
- Same frame with fft_in_ready toggling 1,0 → each word held during stall; 16 accepted; rd_bank toggles.
- 48 back-to-back samples with fft_in_ready = 0 → banks 0 and 1 fill; samples 32..47 dropped; overrun = 1; clr_overrun → 0; after ready = 1 both frames stream in order.
- FFT output bins with bin2 = {+5,−3} (mag 8), bin3 = {0,8} (tie), bin6 = {−2048,0} → max_a = 8, idx_a = 2; max_b = 2048, idx_b = 6; max_valid 1 cycle after bin 15.
- fft_out_last asserted at bin 9 → results reported, next frame bin_cnt starts at 0.
- reset_n low for 1 cycle at sample 7 → all outputs 0; the next 16 samples form a correct frame from bank 0.

Source files
------------

// File: rtl/fft_frame_seq_if.sv
// rtl/fft_frame_seq_if.sv - FFT input/output stream bundle for the frame sequencer
interface fft_frame_seq_if #(
    parameter int DATLEN = 12,
    parameter int FFT_W  = 12
);
    logic [2*DATLEN-1:0] fft_in_data;
    logic                fft_in_valid;
    logic                fft_in_ready;
    logic                fft_in_last;
    logic [2*FFT_W-1:0]  fft_out_data;
    logic                fft_out_valid;
    logic                fft_out_last;

    modport master (
        output fft_in_data,
        output fft_in_valid,
        output fft_in_last,
        input  fft_in_ready,
        input  fft_out_data,
        input  fft_out_valid,
        input  fft_out_last
    );

    modport slave (
        input  fft_in_data,
        input  fft_in_valid,
        input  fft_in_last,
        output fft_in_ready,
        output fft_out_data,
        output fft_out_valid,
        output fft_out_last
    );
endinterface

// File: rtl/fft_frame_seq.sv
// rtl/fft_frame_seq.sv - ping-pong ADC frame buffer, bit-reversed FFT feeder and windowed peak finder
module fft_frame_seq #(
    parameter int DATLEN     = 12,
    parameter int LOG2N      = 4,
    parameter int FFT_W      = 12,
    parameter int OFFSET_BIN = 1,
    parameter int A_LO       = 1,
    parameter int A_HI       = 3,
    parameter int B_LO       = 4,
    parameter int B_HI       = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATLEN-1:0]     smp_data,
    input  logic                  smp_valid,
    fft_frame_seq_if.master       fft,
    input  logic                  clr_overrun,
    output logic [FFT_W:0]        max_a,
    output logic [LOG2N-1:0]      idx_a,
    output logic [FFT_W:0]        max_b,
    output logic [LOG2N-1:0]      idx_b,
    output logic                  max_valid,
    output logic                  overrun
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0]  CNT_LAST = '1;
    localparam logic [DATLEN-1:0] MSB_FLIP = (OFFSET_BIN != 0) ? {1'b1, {(DATLEN-1){1'b0}}} : '0;
    localparam logic [LOG2N-1:0]  A_LO_I = LOG2N'(A_LO);
    localparam logic [LOG2N-1:0]  A_HI_I = LOG2N'(A_HI);
    localparam logic [LOG2N-1:0]  B_LO_I = LOG2N'(B_LO);
    localparam logic [LOG2N-1:0]  B_HI_I = LOG2N'(B_HI);

    typedef enum logic {IDLE, STREAM} rd_state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        for (int i = 0; i < LOG2N; i++) begin
            bitrev[i] = v[LOG2N-1-i];
        end
    endfunction

    logic [DATLEN-1:0] mem [2*N];
    logic [1:0]        full, full_set, full_clr;
    logic              wr_bank, rd_bank;
    logic [LOG2N-1:0]  wr_cnt, ld_cnt;
    logic              ld_done;
    logic              smp_take, smp_drop;
    logic              accept, load, frame_done;
    logic [DATLEN-1:0] rd_word;
    rd_state_t         state, state_nx;

    assign smp_take   = smp_valid & ~full[wr_bank];
    assign smp_drop   = smp_valid &  full[wr_bank];
    assign accept     = fft.fft_in_valid & fft.fft_in_ready;
    assign frame_done = accept & fft.fft_in_last;
    // The output register refills whenever it is empty or being drained this cycle
    assign load       = (state == STREAM) & ~ld_done & (~fft.fft_in_valid | fft.fft_in_ready);
    assign rd_word    = mem[{rd_bank, bitrev(ld_cnt)}] ^ MSB_FLIP;

    // Sample RAM: no reset, contents are don't-care until a frame is written
    always_ff @(posedge clk) begin
        if (smp_take) begin
            mem[{wr_bank, wr_cnt}] <= smp_data;
        end
    end

    // Write pointer: advance on every stored sample, swap banks after the last one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
        end else if (smp_take) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == CNT_LAST) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Per-bank set/clear requests; they always target different banks
    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (smp_take && (wr_cnt == CNT_LAST)) full_set[wr_bank] = 1'b1;
        if (frame_done)                       full_clr[rd_bank] = 1'b1;
    end

    // Bank full flags and sticky overrun; a drop outranks a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full    <= '0;
            overrun <= 1'b0;
        end else begin
            full <= (full & ~full_clr) | full_set;
            if (smp_drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Read FSM next state: stream a frame once its bank is full, idle after its last word leaves
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (full[rd_bank]) state_nx = STREAM;
            STREAM:  if (frame_done)    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read counters: ld_cnt counts words moved into the output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_bank <= 1'b0;
            ld_cnt  <= '0;
            ld_done <= 1'b0;
        end else begin
            if (state == IDLE) begin
                ld_cnt  <= '0;
                ld_done <= 1'b0;
            end else if (load) begin
                ld_cnt <= ld_cnt + 1'b1;
                if (ld_cnt == CNT_LAST) ld_done <= 1'b1;
            end
            if (frame_done) rd_bank <= ~rd_bank;
        end
    end

    // FFT input word register: held while stalled, imag part always zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fft.fft_in_data  <= '0;
            fft.fft_in_valid <= 1'b0;
            fft.fft_in_last  <= 1'b0;
        end else if (load) begin
            fft.fft_in_data  <= {rd_word, {DATLEN{1'b0}}};
            fft.fft_in_valid <= 1'b1;
            fft.fft_in_last  <= (ld_cnt == CNT_LAST);
        end else if (accept) begin
            fft.fft_in_valid <= 1'b0;
            fft.fft_in_last  <= 1'b0;
        end
    end

    logic [FFT_W-1:0] re, im;
    logic [FFT_W:0]   abs_re, abs_im, mag;
    logic [FFT_W:0]   run_a, run_b, nx_a, nx_b;
    logic [LOG2N-1:0] run_ia, run_ib, nx_ia, nx_ib, bin_cnt;
    logic             in_a, in_b, frame_end;

    // Magnitude widened by one bit so that |-2^(FFT_W-1)| is exact
    assign re        = fft.fft_out_data[2*FFT_W-1:FFT_W];
    assign im        = fft.fft_out_data[FFT_W-1:0];
    assign abs_re    = re[FFT_W-1] ? -{re[FFT_W-1], re} : {1'b0, re};
    assign abs_im    = im[FFT_W-1] ? -{im[FFT_W-1], im} : {1'b0, im};
    assign mag       = abs_re + abs_im;
    assign in_a      = (bin_cnt >= A_LO_I) && (bin_cnt <= A_HI_I);
    assign in_b      = (bin_cnt >= B_LO_I) && (bin_cnt <= B_HI_I);
    assign frame_end = fft.fft_out_valid & (fft.fft_out_last | (bin_cnt == CNT_LAST));

    // Running peaks including the current word; strict compare keeps the lowest bin on ties
    always_comb begin
        nx_a  = run_a;
        nx_ia = run_ia;
        nx_b  = run_b;
        nx_ib = run_ib;
        if (fft.fft_out_valid && in_a && (mag > run_a)) begin
            nx_a  = mag;
            nx_ia = bin_cnt;
        end
        if (fft.fft_out_valid && in_b && (mag > run_b)) begin
            nx_b  = mag;
            nx_ib = bin_cnt;
        end
    end

    // Peak tracking, bin counter and per-frame result publication
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_cnt   <= '0;
            run_a     <= '0;
            run_ia    <= A_LO_I;
            run_b     <= '0;
            run_ib    <= B_LO_I;
            max_a     <= '0;
            idx_a     <= '0;
            max_b     <= '0;
            idx_b     <= '0;
            max_valid <= 1'b0;
        end else begin
            max_valid <= frame_end;
            if (frame_end) begin
                max_a   <= nx_a;
                idx_a   <= nx_ia;
                max_b   <= nx_b;
                idx_b   <= nx_ib;
                run_a   <= '0;
                run_ia  <= A_LO_I;
                run_b   <= '0;
                run_ib  <= B_LO_I;
                bin_cnt <= '0;
            end else if (fft.fft_out_valid) begin
                run_a   <= nx_a;
                run_ia  <= nx_ia;
                run_b   <= nx_b;
                run_ib  <= nx_ib;
                bin_cnt <= bin_cnt + 1'b1;
            end
        end
    end
endmodule
